apb_demux: RTL and testbench

Parametrised APB4 one-to-N demultiplexer with registered decode, per-transaction timeout, and decode-error response. It sits between a single APB master (the peripheral bridge out of the uncore bus) and `SLV_NUM` APB slaves (UART, CLINT/PLIC register files, timers, etc.). It generalises the single-port APB request/response bundle to N address-mapped channels. It guarantees that a slave which never raises `pready` cannot hang the core.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_demux_if.sv | 35 +++
 rtl/apb_demux_decode.sv | 32 +++
 rtl/apb_demux.sv | 172 +++++++++++++++++
 tb/tb_apb_demux.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB types: demux FSM state and address-decode result.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

package apb_pkg;

    localparam int SLV_MAX = 16;
    // Wide enough for any SLV_NUM up to SLV_MAX.
    localparam int IDX_W = $clog2(SLV_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DSETUP,
        ST_DACCESS,
        ST_RESP,
        ST_ERR,
        ST_TOUT
    } apb_state_e;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
    } apb_dec_t;

endpackage

// File: rtl/apb_demux_if.sv
// APB4 bus bundle with master/slave views.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface ApbIO #(
    parameter int ADDR_WIDTH = `PADDR_SIZE,
    parameter int DATA_WIDTH = `XLEN
);
    logic                    psel;
    logic                    penable;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [2:0]              pprot;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport master (
        output psel, penable, paddr, pprot,
        output pwrite, pwdata, pstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pprot,
        input  pwrite, pwdata, pstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_demux_decode.sv
// Address decoder: paddr to {hit, idx}; lowest matching index wins.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int SLV_NUM    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    output apb_dec_t              dec_o
);

    logic [ADDR_WIDTH-1:0] base_w;
    logic [ADDR_WIDTH-1:0] mask_w;

    // Walk downwards so the lowest index overwrites last.
    always_comb begin
        dec_o  = '0;
        base_w = '0;
        mask_w = '0;
        for (int i = SLV_NUM - 1; i >= 0; i--) begin
            base_w = SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
            mask_w = SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
            if ((paddr_i & mask_w) == base_w) begin
                dec_o.hit = 1'b1;
                dec_o.idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_demux.sv
// APB4 one-to-N demux with registered decode, timeout and error response.
`ifndef PADDR_SIZE
`define PADDR_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module apb_demux
    import apb_pkg::*;
#(
    parameter int SLV_NUM    = 4,
    parameter int ADDR_WIDTH = `PADDR_SIZE,
    parameter int DATA_WIDTH = `XLEN,
    parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_BASE = '0,
    parameter logic [SLV_NUM*ADDR_WIDTH-1:0] SLV_MASK = '0,
    parameter int TIMEOUT    = 256
) (
    input  logic clk,
    input  logic rst_n,
    ApbIO.slave  up,
    ApbIO.master down [SLV_NUM],
    output logic busy,
    output logic err_pulse
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    apb_dec_t              dec;
    logic [SLV_NUM-1:0]    rdy_v;
    logic [SLV_NUM-1:0]    err_v;
    logic [DATA_WIDTH-1:0] rdata_v [SLV_NUM];
    logic                  sel_rdy;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  drive;
    logic                  access;

    apb_addr_decode #(
        .SLV_NUM    (SLV_NUM),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .paddr_i (up.paddr),
        .dec_o   (dec)
    );

    assign drive  = (state_q == ST_DSETUP) ||
                    (state_q == ST_DACCESS);
    assign access = (state_q == ST_DACCESS);

    for (genvar g = 0; g < SLV_NUM; g++) begin : g_port
        localparam logic [IDX_W-1:0] GI = IDX_W'(g);
        assign down[g].psel    = drive && (idx_q == GI);
        assign down[g].penable = access && (idx_q == GI);
        assign down[g].paddr   = paddr_q;
        assign down[g].pprot   = pprot_q;
        assign down[g].pwrite  = pwrite_q;
        assign down[g].pwdata  = pwdata_q;
        assign down[g].pstrb   = pstrb_q;
        assign rdy_v[g]        = down[g].pready;
        assign err_v[g]        = down[g].pslverr;
        assign rdata_v[g]      = down[g].prdata;
    end

    always_comb begin
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < SLV_NUM; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_rdy   = rdy_v[i];
                sel_err   = err_v[i];
                sel_rdata = rdata_v[i];
            end
        end
    end

    // Upstream side depends on registers only; no down-to-up comb path.
    assign busy       = (state_q != ST_IDLE);
    assign err_pulse  = (state_q == ST_ERR) ||
                        (state_q == ST_TOUT);
    assign up.pready  = err_pulse || (state_q == ST_RESP);
    assign up.pslverr = err_pulse ||
                        ((state_q == ST_RESP) && pslverr_q);
    assign up.prdata  = (state_q == ST_RESP) ? prdata_q : '0;

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pprot_d   = pprot_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        idx_d     = idx_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (up.psel && !up.penable) begin
                    paddr_d  = up.paddr;
                    pprot_d  = up.pprot;
                    pwrite_d = up.pwrite;
                    pwdata_d = up.pwdata;
                    pstrb_d  = up.pstrb;
                    idx_d    = dec.idx;
                    state_d  = dec.hit ? ST_DSETUP : ST_ERR;
                end
            end
            ST_DSETUP: begin
                cnt_d   = '0;
                state_d = ST_DACCESS;
            end
            ST_DACCESS: begin
                if (sel_rdy) begin
                    prdata_d  = sel_rdata;
                    pslverr_d = sel_err;
                    state_d   = ST_RESP;
                end else if (TIMEOUT != 0 &&
                             cnt_q == CNT_LAST) begin
                    state_d = ST_TOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            idx_q     <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pprot_q   <= pprot_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            idx_q     <= idx_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_demux.sv
// Randomized bench for apb_demux against a transaction-level reference.
module tb_apb_demux;

    localparam int N  = 4;
    localparam int TO = 8;
    localparam logic [31:0] B0 = 32'h1000_1000;
    localparam logic [31:0] M0 = 32'hFFFF_F000;
    localparam logic [31:0] B1 = 32'h1000_0000;
    localparam logic [31:0] M1 = 32'hF000_0000;
    localparam logic [31:0] B2 = 32'h2000_0000;
    localparam logic [31:0] M2 = 32'hF000_0000;
    localparam logic [31:0] B3 = 32'h3000_0000;
    localparam logic [31:0] M3 = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_pulse;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] base_m [N] = '{B0, B1, B2, B3};
    logic [31:0] mask_m [N] = '{M0, M1, M2, M3};

    ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) up_if ();
    ApbIO #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dn_if [N] ();

    apb_demux #(
        .SLV_NUM    (N),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .SLV_BASE   ({B3, B2, B1, B0}),
        .SLV_MASK   ({M3, M2, M1, M0}),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up        (up_if),
        .down      (dn_if),
        .busy      (busy),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    logic [N-1:0] ps_v, pe_v, pw_v;
    logic [31:0]  pa_v [N];
    logic [31:0]  pd_v [N];
    logic [3:0]   pb_v [N];
    logic [2:0]   pp_v [N];
    logic [N-1:0] rdy_d, serr_d;
    logic [31:0]  rdata_d [N];

    for (genvar g = 0; g < N; g++) begin : g_s
        assign ps_v[g] = dn_if[g].psel;
        assign pe_v[g] = dn_if[g].penable;
        assign pw_v[g] = dn_if[g].pwrite;
        assign pa_v[g] = dn_if[g].paddr;
        assign pd_v[g] = dn_if[g].pwdata;
        assign pb_v[g] = dn_if[g].pstrb;
        assign pp_v[g] = dn_if[g].pprot;
        assign dn_if[g].pready  = rdy_d[g];
        assign dn_if[g].pslverr = serr_d[g];
        assign dn_if[g].prdata  = rdata_d[g];
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & mask_m[i]) == base_m[i]) return i;
        return -1;
    endfunction

    // One upstream transfer starting at cycle 0 (setup phase).
    task automatic xfer(input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, input int waits,
                        input logic [31:0] rd, input logic se);
        int           tgt, lat, last, rdy_at, oth;
        bit           tout;
        logic [N-1:0] oh;
        logic         e_err;
        logic [31:0]  e_rd;
        tgt    = ref_decode(a);
        tout   = (tgt >= 0) && (waits >= TO);
        lat    = (tgt < 0) ? 1 : (tout ? 2 + TO : 3 + waits);
        rdy_at = tout ? lat + 2 : 2 + waits;
        last   = tout ? lat + 2 : lat;
        e_err  = (tgt < 0) || tout || se;
        e_rd   = ((tgt < 0) || tout) ? 32'h0 : rd;
        oh     = '0;
        if (tgt >= 0) oh[tgt] = 1'b1;
        oth    = (tgt < 0) ? 0 : (tgt + 1) % N;
        for (int c = 0; c <= last; c++) begin
            up_if.psel    = (c <= lat);
            up_if.penable = (c >= 1) && (c <= lat);
            up_if.paddr   = a;
            up_if.pwrite  = wr;
            up_if.pwdata  = wd;
            up_if.pstrb   = st;
            up_if.pprot   = pr;
            rdy_d  = '0;
            serr_d = {N{se}};
            for (int p = 0; p < N; p++) rdata_d[p] = rd;
            if (tgt >= 0 && c == rdy_at) rdy_d[tgt] = 1'b1;
            @(negedge clk);
            chk("up_pready", up_if.pready, c == lat);
            chk("busy", busy, (c >= 1) && (c <= lat));
            chk("err_pulse", err_pulse,
                (c == lat) && ((tgt < 0) || tout));
            chk("psel", ps_v,
                (c >= 1 && c < lat) ? oh : 4'b0);
            chk("penable", pe_v,
                (c >= 2 && c < lat) ? oh : 4'b0);
            if (c == lat) begin
                chk("up_pslverr", up_if.pslverr, e_err);
                chk("up_prdata", up_if.prdata, e_rd);
            end
            if (c == 1 && tgt >= 0) begin
                chk("paddr", pa_v[tgt], a);
                chk("paddr_other", pa_v[oth], a);
                chk("pwrite", pw_v[tgt], wr);
                chk("pwdata", pd_v[tgt], wd);
                chk("pstrb", pb_v[tgt], st);
                chk("pprot", pp_v[tgt], pr);
            end
            @(posedge clk);
            #1;
        end
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
        rdy_d         = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
        up_if.paddr   = '0;
        up_if.pwrite  = 1'b0;
        up_if.pwdata  = '0;
        up_if.pstrb   = '0;
        up_if.pprot   = '0;
        rdy_d         = '0;
        serr_d        = '0;
        for (int p = 0; p < N; p++) rdata_d[p] = '0;

        repeat (3) @(negedge clk);
        chk("rst_psel", ps_v, 0);
        chk("rst_penable", pe_v, 0);
        chk("rst_pwrite", pw_v, 0);
        for (int p = 0; p < N; p++) begin
            chk("rst_paddr", pa_v[p], 0);
            chk("rst_pwdata", pd_v[p], 0);
            chk("rst_pstrb", pb_v[p], 0);
            chk("rst_pprot", pp_v[p], 0);
        end
        chk("rst_up_pready", up_if.pready, 0);
        chk("rst_up_pslverr", up_if.pslverr, 0);
        chk("rst_up_prdata", up_if.prdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_pulse", err_pulse, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0,
             0, 32'h0, 1'b0);
        xfer(32'h2000_0040, 1'b0, 32'h0, 4'h0, 3'd1,
             3, 32'h1234_5678, 1'b1);
        xfer(32'hF000_0000, 1'b0, 32'h0, 4'h0, 3'd0,
             0, 32'h5555_AAAA, 1'b0);
        xfer(32'h3000_0000, 1'b0, 32'h0, 4'h0, 3'd0,
             50, 32'h7777_7777, 1'b0);
        xfer(32'h1000_1234, 1'b1, 32'hCAFE_F00D, 4'h3, 3'd2,
             1, 32'h0, 1'b0);
        xfer(32'h3000_0008, 1'b0, 32'h0, 4'h0, 3'd0,
             TO - 1, 32'hA5A5_5A5A, 1'b0);
        xfer(32'h3000_000C, 1'b0, 32'h0, 4'h0, 3'd0,
             TO, 32'hA5A5_5A5A, 1'b0);

        // Reset asserted while slave 2 is in its access phase.
        up_if.psel    = 1'b1;
        up_if.penable = 1'b0;
        up_if.paddr   = 32'h2000_0010;
        up_if.pwrite  = 1'b0;
        @(posedge clk);
        #1;
        up_if.penable = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_psel", ps_v, 4'b0100);
        chk("pre_rst_penable", pe_v, 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_psel", ps_v, 0);
        chk("mid_rst_penable", pe_v, 0);
        chk("mid_rst_pready", up_if.pready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_paddr", pa_v[2], 0);
        @(posedge clk);
        #1;
        up_if.psel    = 1'b0;
        up_if.penable = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        xfer(32'h2000_0020, 1'b0, 32'h0, 4'h0, 3'd0,
             2, 32'h0BAD_CAFE, 1'b0);

        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            r = $urandom_range(0, 5);
            case (r)
                0: a[31:12] = 20'h10001;
                1: a[31:28] = 4'h1;
                2: a[31:28] = 4'h2;
                3: a[31:28] = 4'h3;
                default: ;
            endcase
            xfer(a, 1'($urandom), $urandom, 4'($urandom),
                 3'($urandom), $urandom_range(0, 11),
                 $urandom, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
